// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide
// steps, then one-cycle done strobe with result and rd for the RF write port.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   start, kill         request new op (when idle/done), abort in-flight op
//   funct3              M-extension opcode (MUL..REMU)
//   rs1_data, rs2_data  operands; rd_in destination index
//   busy                high while iterating
//   done                one-cycle write strobe
//   result, rd_out      write data / address, held until next done
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  fn_q;
  logic [31:0] a_q, b_q, rs1_q;
  logic [63:0] acc_q;
  logic        neg_q, rneg_q, divz_q, ovf_q;
  logic [4:0]  rdp_q;
  logic        busy_q, done_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;

  // Operand decode at acceptance
  logic        sa, sb;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    if (funct3[2]) begin
      sa = ~funct3[0];
      sb = ~funct3[0];
    end else begin
      sa = (funct3 != 3'b011);
      sb = ~funct3[1];
    end
    mag_a = (sa & rs1_data[31]) ? -rs1_data : rs1_data;
    mag_b = (sb & rs2_data[31]) ? -rs2_data : rs2_data;
  end

  // One iteration step
  logic [32:0] sum, trial, diff;
  logic        ge;
  logic [63:0] acc_d;

  always_comb begin
    sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    trial = acc_q[63:31];
    diff  = trial - {1'b0, b_q};
    ge    = ~diff[32];
    if (fn_q[2])
      acc_d = {(ge ? diff[31:0] : trial[31:0]), acc_q[30:0], ge};
    else
      acc_d = {sum, acc_q[31:1]};
  end

  // Sign fix-up and RISC-V special cases on the final step's value
  logic [63:0] prod;
  logic [31:0] quo, rem, res_d;

  always_comb begin
    prod = neg_q ? -acc_d : acc_d;
    quo  = neg_q ? -acc_d[31:0] : acc_d[31:0];
    rem  = rneg_q ? -acc_d[63:32] : acc_d[63:32];
    case (fn_q)
      3'b000: res_d = prod[31:0];
      3'b001,
      3'b010,
      3'b011: res_d = prod[63:32];
      3'b100,
      3'b101: begin
        if (divz_q)
          res_d = 32'hFFFF_FFFF;
        else if (ovf_q & ~fn_q[0])
          res_d = 32'h8000_0000;
        else
          res_d = quo;
      end
      default: begin
        if (divz_q)
          res_d = rs1_q;
        else if (ovf_q & ~fn_q[0])
          res_d = 32'h0;
        else
          res_d = rem;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      fn_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rs1_q    <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rdp_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      rd_q     <= 5'd0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q  <= FINISH;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= res_d;
              rd_q     <= rdp_q;
            end
          end
          default: begin
            if (start) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= 5'd0;
              fn_q    <= funct3;
              a_q     <= mag_a;
              b_q     <= mag_b;
              rs1_q   <= rs1_data;
              rdp_q   <= rd_in;
              // multiply walks the multiplier, divide shifts the dividend
              acc_q   <= {32'd0, funct3[2] ? mag_a : mag_b};
              neg_q   <= (sa & rs1_data[31]) ^ (sb & rs2_data[31]);
              rneg_q  <= sa & rs1_data[31];
              divz_q  <= (rs2_data == 32'd0);
              ovf_q   <= (rs1_data == 32'h8000_0000) &&
                         (rs2_data == 32'hFFFF_FFFF);
            end else begin
              state_q <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table through a scoreboard
// queue, plus hand sequences for ignored start, back-to-back, kill, reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[20];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request through acceptance edge, then scramble the inputs
  task automatic issue(input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input bit push);
    exp_t e;
    funct3   = fn;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    if (push) begin
      e.res = exp;
      e.rd  = rd;
      sbq.push_back(e);
    end
    tick();
    start    = 1'b0;
    funct3   = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = 5'($urandom);
  endtask

  task automatic wait_done(input int n0, output int n);
    exp_t e;
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      chk("done_timeout", 32'(done), 32'd1);
    end else if (sbq.size() == 0) begin
      chk("unexpected_done", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("result", result, e.res);
      chk("rd_out", 32'(rd_out), 32'(e.rd));
      chk("busy_in_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic no_done_window(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int n;

    vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2};
    vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'b110, 32'd5,         32'd0,         32'd5};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{3'b001, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    vecs[13] = '{3'b011, 32'h8000_0000, 32'd2,         32'd1};
    vecs[14] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1};
    vecs[15] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[16] = '{3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
    vecs[17] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    vecs[18] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    vecs[19] = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0};

    rst      = 1'b1;
    start    = 1'b0;
    kill     = 1'b0;
    funct3   = 3'd0;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    rd_in    = 5'd0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].fn, vecs[i].a, vecs[i].b, 5'(i * 3),
            vecs[i].exp, 1'b1);
      chk("busy_after_start", 32'(busy), 32'd1);
      wait_done(0, n);
      chk("latency", n, 32'd32);
      tick();
    end

    // second start at cycle 10 is ignored
    issue(3'b000, 32'd6, 32'd7, 5'd3, 32'd42, 1'b1);
    repeat (9) tick();
    funct3   = 3'b101;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    rd_in    = 5'd9;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("busy_ignored_start", 32'(busy), 32'd1);
    wait_done(10, n);
    chk("latency_ignored", n, 32'd32);
    no_done_window("no_done_after_ignored");

    // back-to-back: start during the done cycle
    issue(3'b111, 32'd100, 32'd7, 5'd4, 32'd2, 1'b1);
    wait_done(0, n);
    chk("latency_b2b_a", n, 32'd32);
    issue(3'b000, 32'd6, 32'd7, 5'd17, 32'd42, 1'b1);
    chk("busy_b2b", 32'(busy), 32'd1);
    wait_done(0, n);
    chk("latency_b2b_b", n, 32'd32);
    tick();

    // kill at cycle 15 of RUN
    issue(3'b101, 32'd1000, 32'd3, 5'd21, 32'd333, 1'b0);
    repeat (14) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_done", 32'(done), 32'd0);
    no_done_window("no_done_after_kill");
    chk("kill_result_held", result, 32'd42);
    chk("kill_rd_held", 32'(rd_out), 32'd17);

    // async reset mid-RUN
    issue(3'b000, 32'd9, 32'd9, 5'd11, 32'd81, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd", 32'(rd_out), 32'd0);
    #1;
    rst = 1'b0;
    no_done_window("no_done_after_reset");
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
